dbus_ctrl: RTL and testbench
============================

DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: clock; all state updates on its posedge.
REQ-002 The module SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-003 The module SHALL have port m_valid, input, 1 bit: memory stage holds a load/store.
REQ-004 The module SHALL have port m_write, input, 1 bit: 1 = store, 0 = load.
REQ-005 The module SHALL have port m_addr, input, 32 bits: byte address.
REQ-006 The module SHALL have port m_wdata, input, 32 bits: store data, right-aligned.
REQ-007 The module SHALL have port m_size, input, msize_t: MSIZE1, MSIZE2 or MSIZE4.
REQ-008 The module SHALL have port m_unsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-009 The module SHALL have port dreq, output, dbus_req_t: request to the data bus.
REQ-010 The module SHALL have port dresp, input, dbus_resp_t: addr_ok, data_ok, data.
REQ-011 The module SHALL have port m_rdata, output, 32 bits: extended load result.
REQ-012 The module SHALL have port stall, output, 1 bit: freezes the pipeline while an access is outstanding.
REQ-013 The module SHALL have port addr_err, output, 1 bit: misaligned-access pulse.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-015 IDLE with m_valid and no error SHALL latch addr, size, write, wdata and unsigned, then go to REQ.
REQ-016 In REQ, dreq.valid SHALL be 1, with fields from the latched copy held stable until addr_ok.
REQ-017 In REQ, addr_ok=1 with data_ok=1 SHALL go to DONE and capture data; addr_ok alone SHALL go to WAIT.
REQ-018 In REQ, data_ok without addr_ok SHALL be ignored.
REQ-019 In WAIT, dreq.valid SHALL be 0, and data_ok SHALL go to DONE and capture data.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-021 In DONE, m_rdata SHALL be valid; outside DONE it SHALL hold its last value.
REQ-022 stall SHALL be combinational: m_valid && state != DONE.
REQ-023 With a zero-wait bus, the minimum latency SHALL be m_valid at cycle 0, REQ at cycle 1, DONE at cycle 2: 2 stall cycles.
REQ-024 m_valid in IDLE on the cycle after DONE SHALL start a new access, with no bubble forced.
REQ-025 Store strobe SHALL be: MSIZE1 4'b0001<<addr[1:0]; MSIZE2 4'b0011<<{addr[1],1'b0}; MSIZE4 4'b1111.
REQ-026 Load strobe SHALL be 0.
REQ-027 dreq.data SHALL be wdata shifted left by 8*addr[1:0].
REQ-028 Load data SHALL be dresp.data shifted right by 8*addr[1:0], truncated to size, then sign- or zero-extended per m_unsigned.
REQ-029 dreq.size SHALL carry the latched size, and dreq.addr the full latched address.

Reset
REQ-030 On resetn=0 the state SHALL be IDLE, with dreq all zero, m_rdata=0 and addr_err=0.
REQ-031 Reset mid-access SHALL abandon the access; a later data_ok SHALL be ignored in IDLE.

Configuration
REQ-032 With DBUS_CTRL_MISALIGN_CHECK_EN defined, IDLE with m_valid and an unaligned address SHALL issue no request.
REQ-033 In that case it SHALL pulse addr_err for one cycle, drop stall that cycle, and remain in IDLE.
REQ-034 Unaligned SHALL mean MSIZE2 with addr[0]=1, or MSIZE4 with addr[1:0]!=0.
REQ-035 Without DBUS_CTRL_MISALIGN_CHECK_EN, addr_err SHALL be tied 0 and every access SHALL be issued as-is.

Structure
REQ-036 The dbus_state_t enum and strobe base constants SHALL live in the shared package; msize_t and dbus_req_t/dbus_resp_t are reused from it.
REQ-037 Strobe, write-shift and load-extend logic SHALL be one combinational sub-module, dbus_align.

Verification
REQ-038 Load word, zero-wait: addr 0x8000_0010, data 0x1234_5678 -> m_rdata 0x1234_5678 in DONE at cycle 2, stall high for cycles 0-1.
REQ-039 Store byte: addr 0x8000_0003, wdata 0xAB -> strobe 4'b1000, dreq.data 0xAB00_0000.
REQ-040 Signed load half: addr 0x...2, data 0x8001_0000 -> 0xFFFF_8001; with m_unsigned -> 0x0000_8001.
REQ-041 addr_ok at cycle 1, data_ok at cycle 4 -> dreq.valid low from cycle 2, DONE at cycle 5, stall high for cycles 0-4.
REQ-042 Reset asserted in WAIT, data_ok arriving next cycle -> state IDLE, m_rdata 0, no DONE.
REQ-043 With DBUS_CTRL_MISALIGN_CHECK_EN, MSIZE4 at addr 0x...2 -> addr_err pulse, dreq.valid never 1.

Source files
------------

// File: rtl/dbus_ctrl_pkg.sv
// rtl/dbus_ctrl_pkg.sv - shared data-bus types, FSM states, strobe bases
// and the alignment helper.
package dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  function automatic logic is_misaligned(input msize_t size, input logic [1:0] offset);
    case (size)
      MSIZE2:  return offset[0];
      MSIZE4:  return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_align.sv
// rtl/dbus_align.sv - combinational store strobe/shift and load
// right-align/extend for one data-bus access.
module dbus_align
  import dbus_ctrl_pkg::*;
(
  input  logic [1:0]  offset,
  input  msize_t      size,
  input  logic        write,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] rdata_sh;

  always_comb begin
    strobe = 4'b0000;
    if (write) begin
      case (size)
        MSIZE1:  strobe = STRB_B << offset;
        MSIZE2:  strobe = STRB_H << {offset[1], 1'b0};
        default: strobe = STRB_W;
      endcase
    end
  end

  assign wdata_out = wdata << {offset, 3'b000};
  assign rdata_sh  = rdata >> {offset, 3'b000};

  always_comb begin
    rdata_out = rdata_sh;
    case (size)
      MSIZE1:  rdata_out = {{24{~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      MSIZE2:  rdata_out = {{16{~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      default: rdata_out = rdata_sh;
    endcase
  end

endmodule

// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - memory-stage data-bus controller (IDLE/REQ/WAIT/DONE).
// Optional misalignment trap: DBUS_CTRL_MISALIGN_CHECK_EN.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic        m_write,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  msize_t      m_size,
  input  logic        m_unsigned,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic [31:0] m_rdata,
  output logic        stall,
  output logic        addr_err
);

  dbus_state_t state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  msize_t      lat_size;
  logic        lat_write;
  logic        lat_unsigned;
  logic [3:0]  strobe;
  logic [31:0] wdata_sh;
  logic [31:0] rdata_ext;

`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
  // Gated by resetn so the trap output reads 0 while held in reset.
  assign addr_err = resetn && (state == IDLE) && m_valid && is_misaligned(m_size, m_addr[1:0]);
`else
  assign addr_err = 1'b0;
`endif

  assign stall = m_valid && (state != DONE) && !addr_err;

  dbus_align u_align (
    .offset      (lat_addr[1:0]),
    .size        (lat_size),
    .write       (lat_write),
    .is_unsigned (lat_unsigned),
    .wdata       (lat_wdata),
    .rdata       (dresp.data),
    .strobe      (strobe),
    .wdata_out   (wdata_sh),
    .rdata_out   (rdata_ext)
  );

  always_comb begin
    dreq = '0;
    if (state == REQ) begin
      dreq.valid  = 1'b1;
      dreq.addr   = lat_addr;
      dreq.size   = lat_size;
      dreq.strobe = strobe;
      dreq.data   = wdata_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= MSIZE1;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      m_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_valid && !addr_err) begin
            lat_addr     <= m_addr;
            lat_wdata    <= m_wdata;
            lat_size     <= m_size;
            lat_write    <= m_write;
            lat_unsigned <= m_unsigned;
            state        <= REQ;
          end
        end
        REQ: begin
          // A data_ok that arrives before the address handshake belongs to no one.
          if (dresp.addr_ok) begin
            if (dresp.data_ok) begin
              m_rdata <= rdata_ext;
              state   <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp.data_ok) begin
            m_rdata <= rdata_ext;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - directed self-checking bench for dbus_ctrl.
module tb_dbus_ctrl;
  import dbus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  msize_t      m_size;
  logic        m_unsigned;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic [31:0] m_rdata;
  logic        stall;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbus_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .m_valid    (m_valid),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_size     (m_size),
    .m_unsigned (m_unsigned),
    .dreq       (dreq),
    .dresp      (dresp),
    .m_rdata    (m_rdata),
    .stall      (stall),
    .addr_err   (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic a, input logic d, input logic [31:0] data);
    dresp.addr_ok = a;
    dresp.data_ok = d;
    dresp.data    = data;
  endtask

  initial begin
    resetn = 1'b0; m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    m_size = MSIZE1; m_unsigned = 1'b0; bus(0, 0, 0);
    tick(); tick(); #2;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_valid", 32'(dreq.valid), 32'd0);
    chk("rst_addr", dreq.addr, 32'd0);
    chk("rst_strobe", 32'(dreq.strobe), 32'd0);
    chk("rst_data", dreq.data, 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);

    // Load word, zero-wait bus
    tick(); resetn = 1'b1; m_valid = 1'b1; m_addr = 32'h8000_0010; m_size = MSIZE4; #2;
    chk("lw_c0_stall", 32'(stall), 32'd1);
    chk("lw_c0_valid", 32'(dreq.valid), 32'd0);
    tick(); bus(1, 1, 32'h1234_5678); #2;
    chk("lw_c1_state", 32'(dut.state), 32'(REQ));
    chk("lw_c1_valid", 32'(dreq.valid), 32'd1);
    chk("lw_c1_addr", dreq.addr, 32'h8000_0010);
    chk("lw_c1_size", 32'(dreq.size), 32'(MSIZE4));
    chk("lw_c1_strobe", 32'(dreq.strobe), 32'd0);
    chk("lw_c1_stall", 32'(stall), 32'd1);
    tick(); bus(0, 0, 0); #2;
    chk("lw_c2_state", 32'(dut.state), 32'(DONE));
    chk("lw_c2_rdata", m_rdata, 32'h1234_5678);
    chk("lw_c2_stall", 32'(stall), 32'd0);
    chk("lw_c2_valid", 32'(dreq.valid), 32'd0);
    m_valid = 1'b0;
    tick(); #2;
    chk("lw_c3_state", 32'(dut.state), 32'(IDLE));
    chk("lw_c3_hold", m_rdata, 32'h1234_5678);

    // Store byte at offset 3, slow data_ok; inputs disturbed after latch
    m_valid = 1'b1; m_write = 1'b1; m_addr = 32'h8000_0003; m_wdata = 32'h0000_00AB; m_size = MSIZE1;
    tick(); m_wdata = 32'hDEAD_BEEF; m_addr = 32'h0; bus(1, 0, 0); #2;
    chk("sb_valid", 32'(dreq.valid), 32'd1);
    chk("sb_strobe", 32'(dreq.strobe), 32'h8);
    chk("sb_data", dreq.data, 32'hAB00_0000);
    chk("sb_addr", dreq.addr, 32'h8000_0003);
    tick(); bus(0, 1, 0); #2;
    chk("sb_wait_state", 32'(dut.state), 32'(WAIT));
    chk("sb_wait_valid", 32'(dreq.valid), 32'd0);
    chk("sb_wait_stall", 32'(stall), 32'd1);
    tick(); bus(0, 0, 0); #2;
    chk("sb_done_state", 32'(dut.state), 32'(DONE));
    chk("sb_done_stall", 32'(stall), 32'd0);

    // Back-to-back signed load half; early data_ok in REQ is ignored
    m_write = 1'b0; m_addr = 32'h8000_0022; m_size = MSIZE2; m_unsigned = 1'b0;
    tick(); #2;
    chk("lh_c0_state", 32'(dut.state), 32'(IDLE));
    chk("lh_c0_stall", 32'(stall), 32'd1);
    tick(); bus(0, 1, 32'h5555_5555); #2;
    chk("lh_c1_state", 32'(dut.state), 32'(REQ));
    chk("lh_c1_size", 32'(dreq.size), 32'(MSIZE2));
    chk("lh_c1_strobe", 32'(dreq.strobe), 32'd0);
    tick(); bus(1, 1, 32'h8001_0000); #2;
    chk("lh_ignored_state", 32'(dut.state), 32'(REQ));
    chk("lh_ignored_valid", 32'(dreq.valid), 32'd1);
    tick(); bus(0, 0, 0); #2;
    chk("lh_done_state", 32'(dut.state), 32'(DONE));
    chk("lh_signed", m_rdata, 32'hFFFF_8001);
    m_unsigned = 1'b1;
    tick(); #2;
    tick(); bus(1, 1, 32'h8001_0000); #2;
    tick(); bus(0, 0, 0); #2;
    chk("lhu_unsigned", m_rdata, 32'h0000_8001);

    // Store half at offset 2
    m_write = 1'b1; m_addr = 32'h1000_0006; m_wdata = 32'h0000_1234; m_size = MSIZE2;
    tick(); #2;
    tick(); bus(1, 1, 0); #2;
    chk("sh_strobe", 32'(dreq.strobe), 32'hC);
    chk("sh_data", dreq.data, 32'h1234_0000);
    tick(); bus(0, 0, 0); m_valid = 1'b0; #2;

    // Load byte, addr_ok at cycle 1 and data_ok at cycle 4
    tick(); m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h8000_0101; m_size = MSIZE1; m_unsigned = 1'b0; #2;
    chk("lat_c0_stall", 32'(stall), 32'd1);
    tick(); bus(1, 0, 0); #2;
    chk("lat_c1_valid", 32'(dreq.valid), 32'd1);
    chk("lat_c1_stall", 32'(stall), 32'd1);
    tick(); bus(0, 0, 0); #2;
    chk("lat_c2_state", 32'(dut.state), 32'(WAIT));
    chk("lat_c2_valid", 32'(dreq.valid), 32'd0);
    chk("lat_c2_stall", 32'(stall), 32'd1);
    tick(); #2;
    chk("lat_c3_valid", 32'(dreq.valid), 32'd0);
    chk("lat_c3_stall", 32'(stall), 32'd1);
    tick(); bus(0, 1, 32'hCAFE_F00D); #2;
    chk("lat_c4_state", 32'(dut.state), 32'(WAIT));
    chk("lat_c4_stall", 32'(stall), 32'd1);
    tick(); bus(0, 0, 0); #2;
    chk("lat_c5_state", 32'(dut.state), 32'(DONE));
    chk("lat_c5_stall", 32'(stall), 32'd0);
    chk("lat_c5_rdata", m_rdata, 32'hFFFF_FFF0);
    m_valid = 1'b0;

    // Reset while in WAIT, stray data_ok afterwards
    tick(); m_valid = 1'b1; m_addr = 32'h8000_0040; m_size = MSIZE4;
    tick(); bus(1, 0, 0);
    tick(); bus(0, 0, 0); #2;
    chk("rw_wait_state", 32'(dut.state), 32'(WAIT));
    resetn = 1'b0;
    tick(); resetn = 1'b1; m_valid = 1'b0; bus(0, 1, 32'h1111_1111); #2;
    chk("rw_state", 32'(dut.state), 32'(IDLE));
    chk("rw_rdata", m_rdata, 32'd0);
    chk("rw_valid", 32'(dreq.valid), 32'd0);
    tick(); bus(0, 0, 0); #2;
    chk("rw_no_done", 32'(dut.state), 32'(IDLE));
    chk("rw_rdata_hold", m_rdata, 32'd0);

    // Misaligned word store at offset 2
    m_valid = 1'b1; m_write = 1'b1; m_size = MSIZE4; m_addr = 32'h8000_0002; m_wdata = 32'h1234_5678; #2;
`ifdef DBUS_CTRL_MISALIGN_CHECK_EN
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_valid", 32'(dreq.valid), 32'd0);
    tick(); #2;
    chk("mis_state", 32'(dut.state), 32'(IDLE));
    chk("mis_valid_next", 32'(dreq.valid), 32'd0);
    m_valid = 1'b0; #2;
    chk("mis_err_clear", 32'(addr_err), 32'd0);
`else
    chk("mis_addr_err", 32'(addr_err), 32'd0);
    chk("mis_stall", 32'(stall), 32'd1);
    tick(); bus(1, 1, 0); #2;
    chk("mis_valid", 32'(dreq.valid), 32'd1);
    chk("mis_addr", dreq.addr, 32'h8000_0002);
    chk("mis_strobe", 32'(dreq.strobe), 32'hF);
    chk("mis_data", dreq.data, 32'h5678_0000);
    tick(); bus(0, 0, 0); m_valid = 1'b0; #2;
    chk("mis_done", 32'(dut.state), 32'(DONE));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
